// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_stage_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
    localparam int          ADDR_W           = 32;
    localparam int          INSN_W           = 32;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,  // free to issue
        ST_WAIT = 2'd1,  // one request outstanding, its response is wanted
        ST_DROP = 2'd2   // one request outstanding, its response is discarded
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, insn} pairs; flush empties it in one cycle.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    input  logic                    flush,
    output logic [WIDTH-1:0]        head,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != FULL);
    assign do_pop  = pop && (count != '0);

    // NOTE: the storage array is deliberately not reset; head is only consumed while count != 0.
    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, small instruction buffer, redirect handling.
// Optional macro FETCH_MISALIGN_TRAP_EN adds a misalign output that halts fetch after a misaligned redirect.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [INSN_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              insn_ready,
    output logic              valid_insn,
    output logic [INSN_W-1:0] insn,
    output logic [ADDR_W-1:0] pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic              misalign
`endif
);

    localparam int           CW      = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    fetch_state_e             state;
    fetch_state_e             state_next;
    logic [ADDR_W-1:0]        fpc;
    logic [CW-1:0]            count;
    logic [CW-1:0]            occ;
    logic [ADDR_W+INSN_W-1:0] head;
    logic                     issue;
    logic                     push;
    logic                     pop;
    logic                     flush;
    logic                     halt;
    logic                     fetch_en;

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            misalign <= 1'b0;
        else if (redirect)
            misalign <= (redirect_pc[1:0] != 2'b00);
    end
    assign halt = misalign;
`else
    assign halt = 1'b0;
`endif

    // Reset gates issue combinationally so imem_req drops the instant rst_n falls.
    assign fetch_en = rst_n && !halt;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        occ        = count;
        if (redirect) begin
            flush      = 1'b1;
            state_next = (state != ST_RUN && !imem_rvalid) ? ST_DROP : ST_RUN;
        end else begin
            pop = valid_insn && insn_ready;
            unique case (state)
                ST_RUN: begin
                    occ = count - CW'(pop);
                    if (fetch_en && occ < DEPTH_C) begin
                        issue      = 1'b1;
                        state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        // Occupancy after this edge decides whether the next request fits.
                        push = 1'b1;
                        occ  = count + CW'(1) - CW'(pop);
                        if (fetch_en && occ < DEPTH_C)
                            issue = 1'b1;
                        else
                            state_next = ST_RUN;
                    end
                end
                ST_DROP: begin
                    if (imem_rvalid)
                        state_next = ST_RUN;
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            fpc   <= RESET_PC;
        end else begin
            state <= state_next;
            if (redirect)
                fpc <= redirect_pc & ~32'h3;
            else if (issue)
                fpc <= fpc + 32'd4;
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (ADDR_W + INSN_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({fpc - 32'd4, imem_rdata}),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .count     (count)
    );

    assign imem_req   = issue;
    assign imem_addr  = fpc;
    assign valid_insn = (count != '0);
    assign pc         = valid_insn ? head[ADDR_W+INSN_W-1:INSN_W] : '0;
    assign insn       = valid_insn ? head[INSN_W-1:0] : '0;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00400000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries (power of two, 2..8).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 imem_req  out  1  instruction-memory read request, held one cycle per request.
REQ-006 imem_addr  out  32  word-aligned byte address, valid with imem_req.
REQ-007 imem_rvalid  in  1  read data valid, at least 1 cycle after its request, in request order.
REQ-008 imem_rdata  in  32  instruction word, valid with imem_rvalid.
REQ-009 redirect  in  1  jump/branch taken; overrides all other events this cycle.
REQ-010 redirect_pc  in  32  new fetch address, sampled when redirect=1.
REQ-011 insn_ready  in  1  downstream decode accepts the head instruction this cycle.
REQ-012 valid_insn  out  1  insn/pc hold a valid fetched instruction.
REQ-013 insn  out  32  instruction word at buffer head.
REQ-014 pc  out  32  byte address of insn.

Function
REQ-015 Fetch PC (fpc) SHALL advance by 4 per issued request, 32-bit wrap-around (32'hFFFFFFFC -> 0).
REQ-016 States: RUN (may issue), WAIT (one request outstanding), DROP (outstanding response to be discarded).
REQ-017 At most one outstanding request; imem_req=1 only in RUN when buffer count + outstanding < BUF_DEPTH.
REQ-018 RUN -> WAIT on issue; WAIT -> RUN on imem_rvalid, pushing {fpc_of_request, imem_rdata} into buffer.
REQ-019 In WAIT, imem_rvalid and issue of the next request SHALL occur in the same cycle when space allows (back-to-back throughput 1 insn/cycle at latency 1).
REQ-020 Buffer: FIFO, head drives insn/pc; valid_insn = (count != 0); pop when valid_insn && insn_ready.
REQ-021 Simultaneous push and pop on a full buffer SHALL be rejected by REQ-017 (never occurs); on a non-full buffer both SHALL take effect, count unchanged.
REQ-022 redirect=1: buffer flushed (valid_insn=0 next cycle), fpc <= redirect_pc, pending pop ignored; state -> DROP if a request is outstanding and its rvalid is not in this cycle, else RUN.
REQ-023 DROP: no issue; imem_rvalid discarded and state -> RUN; a further redirect in DROP updates fpc only.
REQ-024 redirect_pc bits [1:0] SHALL be forced to 0 for fetch.
REQ-025 insn/pc SHALL be stable while valid_insn=1 and insn_ready=0.

Reset
REQ-026 rst_n=0 SHALL immediately force: imem_req=0, valid_insn=0, buffer empty, state RUN, fpc=RESET_PC; insn/pc read 0.
REQ-027 Reset mid-request: any imem_rvalid arriving after deassertion before the first issue SHALL be ignored.
REQ-028 First imem_req SHALL assert in the first cycle after rst_n deasserts.

Configuration
REQ-029 Macro FETCH_MISALIGN_TRAP_EN: when defined, adds output misalign (1 bit) set registered on redirect with redirect_pc[1:0]!=0, cleared by next redirect or reset, and fetch halts (no issue) while set; when undefined, no port, REQ-024 applies silently.

Structure
REQ-030 Shared package holds RESET_PC default, instruction width constant, and the fetch state enum.
REQ-031 Buffer SHALL be a sub-module fetch_fifo (parameterized depth/width, push/pop/flush, count).

Verification
REQ-032 Reset release, imem latency 1, insn_ready=1 -> imem_addr 0x00400000, 0x00400004, ...; valid_insn continuous from cycle 3.
REQ-033 insn_ready=0 for 5 cycles -> exactly BUF_DEPTH entries buffered, imem_req stays 0, insn/pc stable.
REQ-034 redirect to 0x00401000 with response outstanding, latency 3 -> stale word dropped, next valid pc=0x00401000.
REQ-035 fpc=0xFFFFFFFC -> next imem_addr 0x00000000.
REQ-036 rst_n asserted mid-WAIT -> outputs cleared same cycle; late rvalid ignored; fetch restarts at RESET_PC.
REQ-037 With FETCH_MISALIGN_TRAP_EN, redirect_pc 0x00400002 -> misalign=1, imem_req=0 until next aligned redirect.
